store_results: RTL and testbench
================================

# store_results

Write-back stage at the output of the 8-point FFT datapath. Captures one frame of eight 32-bit result words in a single handshake, then streams them one per cycle into an external 16-entry block RAM. The RAM is organised as two ping-pong banks of 8 words, so a downstream reader can drain the previous frame while the next one is written. This is the store-side counterpart of the load stage that feeds the FFT from the input ROM.

## Interface
- N_POINTS, 8, words per frame (fixed; idx width 3)
- DATA_W, 32, result word width; stored verbatim, no reformatting
- ADDR_W, 4, RAM address width = {bank, idx}
- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- in_valid  in  1  y0..y7 hold a complete FFT frame
- in_ready  out  1  block can accept a frame
- y0..y7  in  DATA_W each  FFT results, bin 0..7
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM write address
- ram_din  out  DATA_W  RAM write data
- busy  out  1  frame being written
- done  out  1  one-cycle pulse, frame fully written
- rd_bank  out  1  bank holding most recent complete frame
- rd_valid  out  1  at least one complete frame since reset
- frame_cnt  out  16  completed frames, wraps 0xFFFF->0

## Operation
- States: IDLE, WRITE, DONE.
- IDLE: in_ready=1. Edge with in_valid=1 (the capture edge): latch y0..y7 into buf[0..7], idx<=0, go WRITE. y inputs are don't-care after capture.
- WRITE: each cycle ram_we=1, ram_addr={wr_bank, idx}, ram_din=buf[idx]; idx increments. After idx=7 is presented, go DONE.
- DONE: done=1 for exactly one cycle; rd_bank<=wr_bank, rd_valid<=1, wr_bank<=~wr_bank, frame_cnt<=frame_cnt+1; go IDLE.
- in_ready=(state==IDLE); busy=(state!=IDLE). in_valid outside IDLE is ignored, never queued.
- ram_we/ram_addr/ram_din are registered outputs; ram_addr/ram_din hold last value when ram_we=0.
- Reset values: state IDLE, in_ready 1, busy 0, ram_we 0, ram_addr 0, ram_din 0, done 0, wr_bank 0, rd_bank 0, rd_valid 0, frame_cnt 0, buf all 0.
- Reset mid-WRITE: next cycle ram_we=0, no done, partially written bank is not published (rd_valid 0, rd_bank 0), write restarts at bank 0.
- in_valid and reset_n=0 on same edge: reset wins, frame discarded.

## Timing
- Capture edge E0. ram_we high in cycles E0+1..E0+8 with idx 0..7 in order; done high cycle E0+9; in_ready high again from cycle E0+10.
- Capture-to-done latency 9 cycles; minimum frame interval 10 cycles.
- rd_bank/rd_valid/frame_cnt update on the edge ending the done cycle, visible from E0+10.
- RAM write occurs on the clk edge at the end of each ram_we cycle (single-cycle write, no read-back).

## Structure
- Shared fft package: N_POINTS, DATA_W, ADDR_W constants, store-state enum (IDLE/WRITE/DONE); the load stage also imports N_POINTS and DATA_W.
- No sub-module. The block RAM is an IP instance at the top level. buf is an 8-entry register array selected by idx.

## Test plan
- Reset, then in_valid with y_k=0x0000_0100*(k+1) -> ram_we in cycles 1..8, addr 0x0..0x7, din 0x100,0x200..0x800; done at cycle 9; rd_bank=0, rd_valid=1, frame_cnt=1.
- Second frame y_k=0xDEAD_0000+k held continuously valid -> accepted only when in_ready=1; writes to addr 0x8..0xF; rd_bank=1, frame_cnt=2. Third frame returns to addr 0x0.
- in_valid pulsed during WRITE with y_k=0xFFFF_FFFF -> ignored: no extra writes, buffered data unchanged, no done until the current frame completes.
- reset_n low at the 4th write cycle -> ram_we=0 next cycle, no done, rd_valid=0, frame_cnt=0. The next frame writes addr 0x0..0x7.
- Force frame_cnt to 0xFFFF, complete one frame -> frame_cnt=0x0000, done pulses once.
- Reset asserted on the capture edge -> no writes follow, in_ready=1, state IDLE.

Source files
------------

// File: rtl/store_results_pkg.sv
// Shared FFT datapath constants and the store-stage state encoding.
// Imported by the store stage; the load stage uses N_POINTS and DATA_W.
package store_results_pkg;

    localparam int N_POINTS = 8;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 4;
    localparam int IDX_W    = $clog2(N_POINTS);
    localparam int CNT_W    = 16;

    typedef logic [IDX_W-1:0]  idx_t;
    typedef logic [DATA_W-1:0] word_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_DONE
    } store_state_e;

endpackage

// File: rtl/store_results.sv
// FFT write-back stage: captures an 8-word frame in one handshake and
// streams it into one half of a ping-pong RAM, one word per cycle.
module store_results
    import store_results_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [DATA_W-1:0] i_y0,
    input  logic [DATA_W-1:0] i_y1,
    input  logic [DATA_W-1:0] i_y2,
    input  logic [DATA_W-1:0] i_y3,
    input  logic [DATA_W-1:0] i_y4,
    input  logic [DATA_W-1:0] i_y5,
    input  logic [DATA_W-1:0] i_y6,
    input  logic [DATA_W-1:0] i_y7,
    output logic              o_ram_we,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [DATA_W-1:0] o_ram_din,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_rd_bank,
    output logic              o_rd_valid,
    output logic [CNT_W-1:0]  o_frame_cnt
);

    localparam idx_t IDX_LAST = idx_t'(N_POINTS - 1);

    store_state_e r_state;
    store_state_e w_state_nxt;

    word_t            r_buf [N_POINTS];
    idx_t             r_idx;
    logic             r_wr_bank;
    logic             r_rd_bank;
    logic             r_rd_valid;
    logic [CNT_W-1:0] r_frame_cnt;
    logic             r_ram_we;
    logic [ADDR_W-1:0] r_ram_addr;
    word_t            r_ram_din;

    word_t w_y [N_POINTS];
    logic  w_capture;
    logic  w_advance;
    idx_t  w_idx_nxt;

    assign w_y[0] = i_y0;
    assign w_y[1] = i_y1;
    assign w_y[2] = i_y2;
    assign w_y[3] = i_y3;
    assign w_y[4] = i_y4;
    assign w_y[5] = i_y5;
    assign w_y[6] = i_y6;
    assign w_y[7] = i_y7;

    assign w_capture = (r_state == S_IDLE) && i_in_valid;
    assign w_advance = (r_state == S_WRITE) && (r_idx != IDX_LAST);
    assign w_idx_nxt = r_idx + idx_t'(1);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (i_in_valid) w_state_nxt = S_WRITE;
            S_WRITE: if (r_idx == IDX_LAST) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Word 0 goes out on the capture edge so RAM writes follow it directly.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int k = 0; k < N_POINTS; k++) r_buf[k] <= '0;
            r_idx       <= '0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_din   <= '0;
            r_wr_bank   <= 1'b0;
            r_rd_bank   <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            if (w_capture) begin
                for (int k = 0; k < N_POINTS; k++) r_buf[k] <= w_y[k];
                r_idx      <= '0;
                r_ram_we   <= 1'b1;
                r_ram_addr <= {r_wr_bank, idx_t'(0)};
                r_ram_din  <= w_y[0];
            end else if (w_advance) begin
                r_idx      <= w_idx_nxt;
                r_ram_we   <= 1'b1;
                r_ram_addr <= {r_wr_bank, w_idx_nxt};
                r_ram_din  <= r_buf[w_idx_nxt];
            end else begin
                r_ram_we <= 1'b0;
            end

            if (r_state == S_DONE) begin
                r_rd_bank   <= r_wr_bank;
                r_rd_valid  <= 1'b1;
                r_wr_bank   <= ~r_wr_bank;
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    assign o_in_ready  = (r_state == S_IDLE);
    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = (r_state == S_DONE);
    assign o_ram_we    = r_ram_we;
    assign o_ram_addr  = r_ram_addr;
    assign o_ram_din   = r_ram_din;
    assign o_rd_bank   = r_rd_bank;
    assign o_rd_valid  = r_rd_valid;
    assign o_frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_store_results.sv
// Randomised bench for store_results against a cycle-count reference model.
// The model tracks cycles since capture; outputs are compared every cycle.
module tb_store_results;
    import store_results_pkg::*;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              in_valid;
    logic [DATA_W-1:0] y [N_POINTS];
    logic              in_ready;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic              busy;
    logic              done;
    logic              rd_bank;
    logic              rd_valid;
    logic [15:0]       frame_cnt;

    always #5 clk = ~clk;

    store_results dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_y0        (y[0]),
        .i_y1        (y[1]),
        .i_y2        (y[2]),
        .i_y3        (y[3]),
        .i_y4        (y[4]),
        .i_y5        (y[5]),
        .i_y6        (y[6]),
        .i_y7        (y[7]),
        .o_ram_we    (ram_we),
        .o_ram_addr  (ram_addr),
        .o_ram_din   (ram_din),
        .o_busy      (busy),
        .o_done      (done),
        .o_rd_bank   (rd_bank),
        .o_rd_valid  (rd_valid),
        .o_frame_cnt (frame_cnt)
    );

    // Reference model: m_t = cycles since capture (0 = idle,
    // 1..8 = writing word m_t-1, 9 = done cycle).
    int          m_t;
    logic [31:0] m_frame [N_POINTS];
    int          m_wr_bank, m_rd_bank, m_rd_valid;
    int          m_cnt;
    int          m_addr;
    logic [31:0] m_din;
    int          n_checks = 0;
    int          n_pass = 0;
    int          n_done_seen = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t",
                      tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        m_t = 0;
        m_wr_bank = 0;
        m_rd_bank = 0;
        m_rd_valid = 0;
        m_cnt = 0;
        m_addr = 0;
        m_din = '0;
        for (int k = 0; k < N_POINTS; k++) m_frame[k] = '0;
    endtask

    task automatic model_edge();
        if (!reset_n) begin
            model_reset();
        end else if (m_t == 0) begin
            if (in_valid) begin
                for (int k = 0; k < N_POINTS; k++) m_frame[k] = y[k];
                m_t = 1;
            end
        end else if (m_t < 9) begin
            m_t++;
        end else begin
            m_rd_bank = m_wr_bank;
            m_rd_valid = 1;
            m_wr_bank = 1 - m_wr_bank;
            m_cnt = (m_cnt + 1) % 65536;
            m_t = 0;
        end
        if (m_t >= 1 && m_t <= 8) begin
            m_addr = m_wr_bank * 8 + (m_t - 1);
            m_din = m_frame[m_t - 1];
        end
    endtask

    task automatic compare_all();
        logic exp_we;
        exp_we = (m_t >= 1 && m_t <= 8);
        check("in_ready", 32'(in_ready), 32'(m_t == 0));
        check("busy", 32'(busy), 32'(m_t != 0));
        check("ram_we", 32'(ram_we), 32'(exp_we));
        check("ram_addr", 32'(ram_addr), 32'(m_addr));
        check("ram_din", ram_din, m_din);
        check("done", 32'(done), 32'(m_t == 9));
        check("rd_bank", 32'(rd_bank), 32'(m_rd_bank));
        check("rd_valid", 32'(rd_valid), 32'(m_rd_valid));
        check("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
        if (done) n_done_seen++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_y_rand();
        for (int k = 0; k < N_POINTS; k++) y[k] = $urandom;
    endtask

    task automatic send_one();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int budget;
        budget = 20;
        while (m_t != 0 && budget > 0) begin
            tick();
            budget--;
        end
        check("idle_timeout", 32'(budget > 0), 32'd1);
    endtask

    int d0;

    initial begin
        model_reset();
        reset_n = 1'b0;
        in_valid = 1'b0;
        for (int k = 0; k < N_POINTS; k++) y[k] = '0;
        @(negedge clk);
        run(3);
        reset_n = 1'b1;
        run(2);

        // Frame 1: y_k = 0x100*(k+1), bank 0.
        for (int k = 0; k < N_POINTS; k++) y[k] = 32'h100 * (k + 1);
        send_one();
        run(11);
        check("f1_rd_valid", 32'(rd_valid), 32'd1);
        check("f1_cnt", 32'(frame_cnt), 32'd1);

        // Frames 2 and 3: held-valid source, bank 1 then bank 0.
        for (int k = 0; k < N_POINTS; k++) y[k] = 32'hDEAD_0000 + k;
        in_valid = 1'b1;
        run(20);
        in_valid = 1'b0;
        run(3);
        check("f3_cnt", 32'(frame_cnt), 32'd3);

        // in_valid pulsed mid-write with all-ones data is ignored.
        set_y_rand();
        send_one();
        run(3);
        for (int k = 0; k < N_POINTS; k++) y[k] = 32'hFFFF_FFFF;
        send_one();
        d0 = n_done_seen;
        run(10);
        check("ignore_one_done", 32'(n_done_seen - d0), 32'd1);

        // Reset during the 4th write cycle.
        set_y_rand();
        send_one();
        run(3);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        d0 = n_done_seen;
        run(4);
        check("rst_no_done", 32'(n_done_seen - d0), 32'd0);
        check("rst_cnt", 32'(frame_cnt), 32'd0);
        set_y_rand();
        send_one();
        run(11);

        // Reset on the capture edge discards the frame.
        set_y_rand();
        in_valid = 1'b1;
        reset_n = 1'b0;
        tick();
        in_valid = 1'b0;
        reset_n = 1'b1;
        run(3);
        check("rstcap_ready", 32'(in_ready), 32'd1);

        // Random traffic with occasional resets.
        for (int i = 0; i < 300; i++) begin
            set_y_rand();
            in_valid = ($urandom_range(0, 3) == 0);
            reset_n = ($urandom_range(0, 60) != 0);
            tick();
        end
        reset_n = 1'b1;
        in_valid = 1'b0;
        wait_idle();

        // Frame counter wrap.
        @(negedge clk);
        force dut.r_frame_cnt = 16'hFFFF;
        #1;
        release dut.r_frame_cnt;
        m_cnt = 16'hFFFF;
        run(1);
        set_y_rand();
        send_one();
        d0 = n_done_seen;
        run(11);
        check("wrap_cnt", 32'(frame_cnt), 32'h0);
        check("wrap_one_done", 32'(n_done_seen - d0), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
